// File: rtl/irq_vector_controller_pkg.sv
// Shared constants for the vectored interrupt controller:
// register offsets, VECTOR valid-bit position, source limit.
package irq_vector_controller_pkg;

  localparam int MAX_SOURCES   = 15;
  localparam int VEC_VALID_BIT = 15;

  localparam logic [2:0] REG_IRQV_FLAG    = 3'd0;
  localparam logic [2:0] REG_IRQV_MASK    = 3'd1;
  localparam logic [2:0] REG_IRQV_USER    = 3'd2;
  localparam logic [2:0] REG_IRQV_MODE    = 3'd3;
  localparam logic [2:0] REG_IRQV_PENDING = 3'd4;
  localparam logic [2:0] REG_IRQV_VECTOR  = 3'd5;
  localparam logic [2:0] REG_IRQV_HOLDOFF = 3'd6;

endpackage

// File: rtl/irqv_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports: req (W bits) in; idx (4 bits) and valid out.
module irqv_prio_enc #(
  parameter int W = 5
) (
  input  logic [W-1:0] req,
  output logic [3:0]   idx,
  output logic         valid
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_vector_controller.sv
// Wishbone-slave vectored interrupt controller: NUM_SOURCES hw
// sources plus one user source, edge/level mode, pending and
// priority vector registers, registered irq_o.
// Ports: wb_* Wishbone slave (16-bit, adr[2:0] decoded),
// irq_i event inputs, irq_o interrupt request.
// Optional macro IRQC_HOLDOFF_EN adds the HOLDOFF register at
// address 6 and an irq_o suppression down-counter.
module irq_vector_controller
  import irq_vector_controller_pkg::*;
#(
  parameter int          NUM_SOURCES = 4,
  parameter logic [15:0] RESET_MASK  = 16'h0000,
  parameter logic [15:0] RESET_MODE  = 16'h0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [15:0]            wb_adr_i,
  input  logic [15:0]            wb_dat_i,
  output logic [15:0]            wb_dat_o,
  output logic                   wb_ack_o,
  input  logic [NUM_SOURCES-1:0] irq_i,
  output logic                   irq_o
);

  localparam int N = NUM_SOURCES;
  localparam int W = N + 1;

  if (NUM_SOURCES < 1 || NUM_SOURCES > MAX_SOURCES) begin : g_chk
    $error("NUM_SOURCES out of range");
  end

  logic [W-1:0] flag;
  logic [W-1:0] mask;
  logic [W-1:0] pend;
  logic [W-1:0] flag_set;
  logic [W-1:0] flag_clr;
  logic [N-1:0] mode;
  logic [N-1:0] prev;

  logic         access;
  logic         wr;
  logic [2:0]   reg_sel;
  logic         wr_flag;
  logic         wr_mask;
  logic         wr_user;
  logic         wr_mode;
  logic [15:0]  rd_data;
  logic [15:0]  vector;
  logic [3:0]   vec_idx;
  logic         vec_valid;
  logic         hold_ok;

  // A strobe held through ack is seen again only once ack drops,
  // giving one ack every second cycle.
  assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = access & wb_we_i;
  assign reg_sel = wb_adr_i[2:0];
  assign wr_flag = wr && (reg_sel == REG_IRQV_FLAG);
  assign wr_mask = wr && (reg_sel == REG_IRQV_MASK);
  assign wr_user = wr && (reg_sel == REG_IRQV_USER);
  assign wr_mode = wr && (reg_sel == REG_IRQV_MODE);

  always_comb begin
    flag_set        = '0;
    flag_set[N-1:0] = irq_i & (~mode | ~prev);
    flag_set[N]     = wr_user;
  end

  assign flag_clr = wr_flag ? wb_dat_i[W-1:0] : '0;
  assign pend     = flag & mask;

  irqv_prio_enc #(
    .W (W)
  ) u_enc (
    .req   (pend),
    .idx   (vec_idx),
    .valid (vec_valid)
  );

  always_comb begin
    vector                = 16'h0000;
    vector[VEC_VALID_BIT] = vec_valid;
    vector[3:0]           = vec_idx;
  end

`ifdef IRQC_HOLDOFF_EN
  logic [15:0] holdoff;
  logic [15:0] hold_cnt;
  logic        wr_hold;

  assign wr_hold = wr && (reg_sel == REG_IRQV_HOLDOFF);
  assign hold_ok = (hold_cnt == 16'd0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      holdoff  <= 16'd0;
      hold_cnt <= 16'd0;
    end else begin
      if (wr_hold) holdoff <= wb_dat_i;
      if (wr_flag) hold_cnt <= holdoff;
      else if (hold_cnt != 16'd0)
        hold_cnt <= hold_cnt - 16'd1;
    end
  end
`else
  assign hold_ok = 1'b1;
`endif

  always_comb begin
    rd_data = 16'h0000;
    unique case (reg_sel)
      REG_IRQV_FLAG:    rd_data = 16'(flag);
      REG_IRQV_MASK:    rd_data = 16'(mask);
      REG_IRQV_MODE:    rd_data = 16'(mode);
      REG_IRQV_PENDING: rd_data = 16'(pend);
      REG_IRQV_VECTOR:  rd_data = vector;
`ifdef IRQC_HOLDOFF_EN
      REG_IRQV_HOLDOFF: rd_data = holdoff;
`endif
      default:          rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 16'h0000;
      irq_o    <= 1'b0;
      flag     <= '0;
      mask     <= RESET_MASK[W-1:0];
      mode     <= RESET_MODE[N-1:0];
      prev     <= '0;
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= rd_data;
      // Set after clear: a same-cycle set condition wins.
      flag  <= (flag & ~flag_clr) | flag_set;
      irq_o <= hold_ok & (|pend);
      if (wr_mask) mask <= wb_dat_i[W-1:0];
      if (wr_mode) mode <= wb_dat_i[N-1:0];
      // Forget history of bits switched to edge mode so a held
      // input yields one fresh edge.
      if (wr_mode) prev <= irq_i & ~wb_dat_i[N-1:0];
      else         prev <= irq_i;
    end
  end

  logic unused;
  assign unused = &{1'b0, wb_adr_i[15:3], wb_dat_i};

endmodule

// File: tb/tb_irq_vector_controller.sv
// Directed bench for irq_vector_controller (NUM_SOURCES=4):
// vector table plus hand sequences for timing corner cases.
module tb_irq_vector_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack;
  logic [3:0]  irq;
  logic        irq_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_vector_controller #(
    .NUM_SOURCES (4),
    .RESET_MASK  (16'h0000),
    .RESET_MODE  (16'h0000)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .irq_i    (irq),
    .irq_o    (irq_out)
  );

  typedef struct {
    logic [3:0]  irq;
    int          settle;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a clock edge; returns just after the ack edge.
  task automatic xfer(input logic w, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] rd);
    int  cnt;
    logic got;
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    adr   = a;
    dat_i = d;
    got   = 1'b0;
    cnt   = 0;
    while (!got && cnt < 4) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ack) got = 1'b1;
    end
    rd  = dat_o;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack adr %h", a);
    end
  endtask

  initial begin
    logic [15:0] rd;
    int acks;
    int lows;
    logic done;

    rst   = 1'b1;
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    adr   = 16'h0;
    dat_i = 16'h0;
    irq   = 4'h0;
    tick(3);
    rst = 1'b0;
    chk("reset_irq_o", 32'(irq_out), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_dat_o", 32'(dat_o), 32'd0);

    // irq, settle, we, adr, wdat, exp_rd, exp_irq
    tbl.push_back('{4'h0, 1, 1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd4, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd5, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd1, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd1, 16'hFFFF, 16'h0000, 1'b0});
    tbl.push_back('{4'hF, 2, 1'b0, 16'd0, 16'h0000, 16'h000F, 1'b1});
    tbl.push_back('{4'hF, 1, 1'b0, 16'd1, 16'h0000, 16'h001F, 1'b1});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd0, 16'h001F, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd1, 16'h001C, 16'h0000, 1'b0});
    tbl.push_back('{4'h3, 2, 1'b0, 16'd4, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h3, 1, 1'b0, 16'd0, 16'h0000, 16'h0003, 1'b0});
    tbl.push_back('{4'h7, 2, 1'b0, 16'd5, 16'h0000, 16'h8002, 1'b1});
    tbl.push_back('{4'h7, 1, 1'b0, 16'd4, 16'h0000, 16'h0004, 1'b1});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd0, 16'h001F, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd1, 16'h0010, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd2, 16'h1234, 16'h0000, 1'b1});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd0, 16'h0000, 16'h0010, 1'b1});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd5, 16'h0000, 16'h8004, 1'b1});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd2, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd0, 16'h0010, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd7, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd7, 16'hFFFF, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd6, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd3, 16'hFFFF, 16'h0000, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b0, 16'd3, 16'h0000, 16'h000F, 1'b0});
    tbl.push_back('{4'h0, 1, 1'b1, 16'd3, 16'h0000, 16'h0000, 1'b0});

    foreach (tbl[i]) begin
      irq = tbl[i].irq;
      tick(tbl[i].settle);
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, rd);
      if (!tbl[i].we)
        chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(tbl[i].exp_rd));
      tick(2);
      chk($sformatf("vec%0d_irq", i), 32'(irq_out),
          32'(tbl[i].exp_irq));
    end

    // irq_i rise at k: flag at k+1, irq_o at k+2; clear drops at c+1.
    irq = 4'h0;
    xfer(1'b1, 16'd1, 16'h0001, rd);
    tick(1);
    irq = 4'h1;
    tick(1);
    chk("lat_k1_irq", 32'(irq_out), 32'd0);
    tick(1);
    chk("lat_k2_irq", 32'(irq_out), 32'd1);
    irq = 4'h0;
    tick(1);
    xfer(1'b1, 16'd0, 16'h0001, rd);
    chk("clr_c_irq", 32'(irq_out), 32'd1);
    tick(1);
    chk("clr_c1_irq", 32'(irq_out), 32'd0);

    // Edge mode on bit0 with input held; level bit1 set-wins.
    xfer(1'b1, 16'd1, 16'h0000, rd);
    xfer(1'b1, 16'd3, 16'h0001, rd);
    irq = 4'h1;
    tick(3);
    xfer(1'b0, 16'd0, 16'h0000, rd);
    chk("edge_once_flag", 32'(rd), 32'h0001);
    xfer(1'b1, 16'd0, 16'h0001, rd);
    tick(3);
    xfer(1'b0, 16'd0, 16'h0000, rd);
    chk("edge_held_flag", 32'(rd), 32'h0000);
    irq = 4'h3;
    tick(2);
    xfer(1'b1, 16'd0, 16'h0002, rd);
    tick(1);
    xfer(1'b0, 16'd0, 16'h0000, rd);
    chk("set_wins_flag", 32'(rd), 32'h0002);
    irq = 4'h0;
    tick(1);
    xfer(1'b1, 16'd3, 16'h0000, rd);
    xfer(1'b1, 16'd0, 16'h001F, rd);

    // Strobe held for six cycles yields an ack every other cycle.
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = 1'b0;
    adr  = 16'd0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (ack) acks++;
    end
    cyc = 1'b0;
    stb = 1'b0;
    chk("held_stb_acks", 32'(acks), 32'd3);
    tick(2);

`ifdef IRQC_HOLDOFF_EN
    xfer(1'b1, 16'd6, 16'h0008, rd);
    xfer(1'b0, 16'd6, 16'h0000, rd);
    chk("holdoff_rd", 32'(rd), 32'h0008);
    xfer(1'b1, 16'd1, 16'h0001, rd);
    irq = 4'h1;
    tick(3);
    xfer(1'b1, 16'd0, 16'h0001, rd);
    lows = 0;
    done = 1'b0;
    for (int j = 0; j < 20 && !done; j++) begin
      tick(1);
      if (irq_out) done = 1'b1;
      else lows++;
    end
    chk("holdoff_low_cycles", 32'(lows), 32'd8);
    irq = 4'h0;
    tick(1);
    xfer(1'b1, 16'd0, 16'h001F, rd);
    tick(2);
`endif

    // Reset during a pending access: no ack, registers restored.
    xfer(1'b1, 16'd1, 16'h001F, rd);
    tick(1);
    cyc = 1'b1;
    stb = 1'b1;
    adr = 16'd1;
    rst = 1'b1;
    tick(1);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    cyc = 1'b0;
    stb = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    xfer(1'b0, 16'd1, 16'h0000, rd);
    chk("rst_mid_mask", 32'(rd), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_vector_controller.md
Name: irq_vector_controller

Overview:
Parametrised Wishbone-slave interrupt controller that generalises the existing irq_controller.
- Aggregates NUM_SOURCES synchronous event inputs plus one software (user) source into a single irq_o.
- Adds per-source edge/level mode, a read-only pending register and a priority-encoded vector register.
- Sits on the monitor Wishbone bus and drives the processor interrupt line.

Parameters:
NUM_SOURCES, 4, number of hardware sources; legal range 1..15; flag bit NUM_SOURCES is the user source.
RESET_MASK, 16'h0000, MASK register value after reset (1 = enabled).
RESET_MODE, 16'h0000, MODE register value after reset (1 = rising edge, 0 = level).

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge.
wb_rst_i  in  1  synchronous active-high reset.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  write enable.
wb_adr_i  in  16  word address; only [2:0] decoded.
wb_dat_i  in  16  write data.
wb_dat_o  out  16  read data.
wb_ack_o  out  1  single-cycle acknowledge.
irq_i  in  NUM_SOURCES  event inputs, synchronous to wb_clk_i.
irq_o  out  1  registered interrupt request.

Behaviour:
- Width rule: N = NUM_SOURCES; W = N+1 active register bits. Bits [15:W] of every register read as 0 and ignore writes.
- Register map (word addresses):
  - 0 FLAG: R; write-1-to-clear.
  - 1 MASK: RW.
  - 2 USER: W, any write sets flag[N]; reads 0.
  - 3 MODE: RW; bits [N-1:0] only, user bit always edge.
  - 4 PENDING: RO, FLAG & MASK.
  - 5 VECTOR: RO; bit15 = any pending, [3:0] = lowest pending index.
  - 6 HOLDOFF: see Optional Feature.
  - 7: unmapped.
- Unmapped addresses: reads return 0, writes are ignored, ack is still given.
- Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, FLAG=0, MASK=RESET_MASK, MODE=RESET_MODE, edge history register=0.
- Wishbone handshake:
  - wb_ack_o asserts the cycle after cyc&stb is seen with ack low; it is high for exactly one cycle.
  - Write takes effect on the ack edge. wb_dat_o is valid in the ack cycle and holds until the next access.
  - A strobe held through ack produces a new ack every second cycle; there are no wait states.
- Flag set:
  - Level source i: flag[i] set every cycle irq_i[i]=1.
  - Edge source i: flag[i] set when irq_i[i]=1 and prev[i]=0; prev updates every cycle.
- Clear/set collision: if a FLAG W1C write and a set condition hit the same bit in the same cycle, set wins and the flag stays 1. A level source therefore cannot be cleared while its input is high.
- Mode write: writing MODE clears prev for the affected bits, so a held-high input produces one edge after switching to edge mode.
- Interrupt output: irq_o <= |(FLAG & MASK), registered.
  - Latency: irq_i rising at cycle k gives flag at k+1 and irq_o at k+2.
  - A clear written on ack cycle c drops irq_o at c+1 if nothing re-sets it.
- Mask: masking does not clear flags; unmasking a set flag raises irq_o next cycle.
- VECTOR: combinational from PENDING, lowest index wins, so user (index N) is lowest priority. With nothing pending it reads 16'h0000.
- Reset mid-transfer: aborts the transfer (no ack) and restores all reset values.

Optional Feature:
Macro IRQC_HOLDOFF_EN.
- Defined:
  - Register 6 HOLDOFF is RW, 16 bits, reset 0.
  - Any FLAG write loads a down-counter with HOLDOFF. irq_o is forced 0 while the counter is nonzero; flags still accumulate.
  - irq_o re-evaluates the cycle the counter reaches 0. HOLDOFF=0 gives no suppression.
- Undefined: address 6 is unmapped, no counter logic is present, and irq_o follows the base rule.

Decomposition:
- Shared header irq_vector_controller.vh holds:
  - register offset defines REG_IRQV_FLAG, MASK, USER, MODE, PENDING, VECTOR, HOLDOFF;
  - VECTOR valid-bit position;
  - maximum source count (15).
- Sub-module irqv_prio_enc: parametrised lowest-index-first priority encoder, W-bit in, 4-bit index plus valid out.
- Wishbone decode, flag and edge logic live in the top module.

Test Plan (NUM_SOURCES=4, MODE=0, MASK=0 unless stated):
1. Reset, read FLAG/PENDING/VECTOR -> all 16'h0000, irq_o=0. Read MASK -> RESET_MASK.
2. irq_i=4'b1111, MASK=5'b11111, read FLAG -> 16'h000F, irq_o=1. Set irq_i=0, write FLAG 16'h001F -> FLAG 0, irq_o=0 next cycle.
3. MASK=5'b11100, irq_i=4'b0011 -> irq_o stays 0, PENDING=0. Then irq_i=4'b0111 -> irq_o=1, VECTOR=16'h8002.
4. MODE=4'b0001, hold irq_i[0]=1, write FLAG 16'h0001 -> FLAG bit0 stays 0. Level bit1 held high, W1C bit1 -> bit1 remains 1 (set wins).
5. Write USER any value with MASK=5'b10000 -> FLAG=16'h0010, irq_o=1, VECTOR=16'h8004. W1C 16'h0010 -> irq_o=0.
6. IRQC_HOLDOFF_EN, HOLDOFF=8, MASK=5'b00001, irq_i[0] level high, write FLAG 1 -> irq_o low exactly 8 cycles, then 1.
